// File: rtl/fetch_run_controller.sv
//-----------------------------------------------------------------------------
// fetch_run_controller
//
// Purpose:
//   Sequences the instruction fetch pipeline from a byte-wide command stream
//   (typically a UART receiver). Program words arrive MSB-first and are
//   written into program memory. The pipeline is then released either for
//   continuous execution or for single-step execution. A halt reported by
//   the fetch unit ends the run.
//
// Commands (ASCII):
//   'L' (0x4C)  load program words, in the IDLE state
//   'C' (0x43)  run continuously, in IDLE or STEP_WAIT
//   'S' (0x53)  enter single-step mode, in IDLE
//   'N' (0x4E)  advance one step, in STEP_WAIT
//
// Optional build macro:
//   CYCLE_LIMIT_EN - adds a RUN-mode watchdog. When the cycle counter reaches
//                    MAX_CYCLES-1 without a halt, the run is forced to DONE
//                    and o_timeout is raised. Without the macro there is no
//                    o_timeout port, and RUN lasts until i_halt.
//
// Ports:
//   i_clock        clock
//   i_reset        synchronous, active-high reset
//   i_rx_data      command/data byte
//   i_rx_valid     byte valid
//   o_rx_ready     byte accepted when i_rx_valid & o_rx_ready
//   i_halt         fetch unit sees an all-zero (halt) instruction
//   o_mem_wr_en    program memory write strobe (one cycle per word)
//   o_mem_wr_addr  write address (word index)
//   o_mem_wr_data  write data
//   o_pipe_enable  pipeline advances this cycle
//   o_pipe_reset   pipeline/PC held in reset
//   o_state        current state encoding
//   o_cycle_count  enabled cycles since run start (saturating)
//   o_done         program halted; high in DONE
//   o_load_err     program overflowed memory without a halt word
//   o_timeout      watchdog expired (CYCLE_LIMIT_EN builds only)
//-----------------------------------------------------------------------------
module fetch_run_controller #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 10,
  parameter int NB_CYCLE   = 32,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_rx_ready,
  input  logic                i_halt,
  output logic                o_mem_wr_en,
  output logic [NB_ADDR-1:0]  o_mem_wr_addr,
  output logic [NB_DATA-1:0]  o_mem_wr_data,
  output logic                o_pipe_enable,
  output logic                o_pipe_reset,
  output logic [2:0]          o_state,
  output logic [NB_CYCLE-1:0] o_cycle_count,
  output logic                o_done,
  output logic                o_load_err
`ifdef CYCLE_LIMIT_EN
  ,
  output logic                o_timeout
`endif
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_IDX-1:0]  LAST_IDX  = NB_IDX'(NB_BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;

`ifdef CYCLE_LIMIT_EN
  localparam logic [NB_CYCLE-1:0] CYCLE_LIMIT = NB_CYCLE'(MAX_CYCLES - 1);
`endif

  // Elaboration-time parameter sanity checks.
  if ((NB_DATA < 8) || ((NB_DATA % 8) != 0)) begin : g_bad_data_width
    $error("fetch_run_controller: NB_DATA must be a non-zero multiple of 8");
  end
  if (MAX_CYCLES < 1) begin : g_bad_max_cycles
    $error("fetch_run_controller: MAX_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_RUN        = 3'd2,
    ST_STEP_WAIT  = 3'd3,
    ST_STEP_PULSE = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  state_t              state;
  state_t              next_state;

  logic                rx_accept;
  logic                is_load;
  logic                is_cont;
  logic                is_step;
  logic                is_next;

  logic [NB_DATA-1:0]  asm_buf;
  logic [NB_IDX-1:0]   byte_idx;
  logic [NB_ADDR-1:0]  addr;
  logic [NB_DATA-1:0]  assembled_word;
  logic                word_last;
  logic                counter_clear;
  logic                count_at_max;

  assign rx_accept = i_rx_valid & o_rx_ready;

  assign is_load = (i_rx_data == CMD_LOAD);
  assign is_cont = (i_rx_data == CMD_CONT);
  assign is_step = (i_rx_data == CMD_STEP);
  assign is_next = (i_rx_data == CMD_NEXT);

  // The word as it will stand once the byte on i_rx_data is shifted in.
  // On the last byte this is the value that goes to memory.
  assign assembled_word = (asm_buf << 8) | NB_DATA'(i_rx_data);
  assign word_last      = (byte_idx == LAST_IDX);

  // A fresh run ('C' or 'S' from IDLE) restarts the cycle count.
  assign counter_clear = (state == ST_IDLE) && rx_accept && (is_cont || is_step);
  assign count_at_max  = &o_cycle_count;

  assign o_state = state;

  //---------------------------------------------------------------------------
  // State register
  //---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  //---------------------------------------------------------------------------
  // Next-state logic
  //---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (rx_accept) begin
          if (is_load) begin
            next_state = ST_LOAD;
          end else if (is_cont) begin
            next_state = ST_RUN;
          end else if (is_step) begin
            next_state = ST_STEP_WAIT;
          end
        end
      end

      // Loading ends on a halt word, or on a non-zero word at the last
      // address. The state leaves on the accept edge; the write strobe
      // itself appears in the following cycle.
      ST_LOAD: begin
        if (rx_accept && word_last) begin
          if ((assembled_word == '0) || (addr == LAST_ADDR)) begin
            next_state = ST_IDLE;
          end
        end
      end

      ST_RUN: begin
        if (i_halt) begin
          next_state = ST_DONE;
        end
`ifdef CYCLE_LIMIT_EN
        else if (o_cycle_count == CYCLE_LIMIT) begin
          next_state = ST_DONE;
        end
`endif
      end

      ST_STEP_WAIT: begin
        if (rx_accept) begin
          if (is_next) begin
            next_state = ST_STEP_PULSE;
          end else if (is_cont) begin
            next_state = ST_RUN;
          end else if (!is_step) begin
            next_state = ST_IDLE;
          end
        end
      end

      ST_STEP_PULSE: begin
        next_state = i_halt ? ST_DONE : ST_STEP_WAIT;
      end

      ST_DONE: begin
        if (rx_accept) begin
          next_state = ST_IDLE;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  //---------------------------------------------------------------------------
  // State-decoded outputs. The pipeline is held in reset while idle or
  // loading, so every run starts with the PC at 0.
  //---------------------------------------------------------------------------
  always_comb begin
    o_rx_ready    = 1'b0;
    o_pipe_enable = 1'b0;
    o_pipe_reset  = 1'b0;
    o_done        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        o_rx_ready   = 1'b1;
        o_pipe_reset = 1'b1;
      end
      ST_LOAD: begin
        o_rx_ready   = 1'b1;
        o_pipe_reset = 1'b1;
      end
      ST_RUN: begin
        o_pipe_enable = 1'b1;
      end
      ST_STEP_WAIT: begin
        o_rx_ready = 1'b1;
      end
      ST_STEP_PULSE: begin
        o_pipe_enable = 1'b1;
      end
      ST_DONE: begin
        o_rx_ready = 1'b1;
        o_done     = 1'b1;
      end
      default: begin
        o_pipe_reset = 1'b1;
      end
    endcase
  end

  //---------------------------------------------------------------------------
  // Load datapath: byte assembly, memory write strobe and address tracking.
  // The address never wraps; at the last location it stays put and a
  // non-zero word there flags an overflow.
  //---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_mem_wr_en   <= 1'b0;
      o_mem_wr_addr <= '0;
      o_mem_wr_data <= '0;
      addr          <= '0;
      asm_buf       <= '0;
      byte_idx      <= '0;
      o_load_err    <= 1'b0;
    end else begin
      o_mem_wr_en <= 1'b0;
      if ((state == ST_IDLE) && rx_accept && is_load) begin
        addr       <= '0;
        asm_buf    <= '0;
        byte_idx   <= '0;
        o_load_err <= 1'b0;
      end else if ((state == ST_LOAD) && rx_accept) begin
        if (word_last) begin
          o_mem_wr_en   <= 1'b1;
          o_mem_wr_data <= assembled_word;
          o_mem_wr_addr <= addr;
          asm_buf       <= '0;
          byte_idx      <= '0;
          if (addr != LAST_ADDR) begin
            addr <= addr + 1'b1;
          end else if (assembled_word != '0) begin
            o_load_err <= 1'b1;
          end
        end else begin
          asm_buf  <= assembled_word;
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  //---------------------------------------------------------------------------
  // Cycle counter: counts every enabled pipeline cycle, including the one in
  // which the halt is sampled, and sticks at all-ones instead of wrapping.
  // It is frozen outside RUN/STEP_PULSE, so DONE holds the final count.
  //---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_cycle_count <= '0;
    end else if (counter_clear) begin
      o_cycle_count <= '0;
    end else if (o_pipe_enable && !count_at_max) begin
      o_cycle_count <= o_cycle_count + 1'b1;
    end
  end

`ifdef CYCLE_LIMIT_EN
  //---------------------------------------------------------------------------
  // Watchdog flag: raised when RUN is forced to DONE by the cycle limit, and
  // kept until the next 'C' or 'S' command starts a new run.
  //---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_timeout <= 1'b0;
    end else if (counter_clear || ((state == ST_STEP_WAIT) && rx_accept && is_cont)) begin
      o_timeout <= 1'b0;
    end else if ((state == ST_RUN) && !i_halt && (o_cycle_count == CYCLE_LIMIT)) begin
      o_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/fetch_run_controller.md
Name: fetch_run_controller

Overview:
- Sequences the instruction fetch pipeline from a byte-wide command stream, such as a UART receiver.
- Loads 32-bit words into program memory, releases the pipeline for continuous or single-step execution, and detects halt.
- Sits between the UART receiver, the program memory write port and the enable/reset inputs of the fetch/pipeline.

Parameters:
NB_DATA, 32, instruction word width; must be a multiple of 8
NB_ADDR, 10, program memory address width (depth 2**NB_ADDR)
NB_CYCLE, 32, cycle counter width
MAX_CYCLES, 1000000, watchdog limit (used only with CYCLE_LIMIT_EN)

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  8  command/data byte
i_rx_valid  in  1  byte valid
o_rx_ready  out  1  byte accepted when valid&ready
i_halt  in  1  fetch unit sees an all-zero (halt) instruction
o_mem_wr_en  out  1  program memory write strobe
o_mem_wr_addr  out  NB_ADDR  write address (word index)
o_mem_wr_data  out  NB_DATA  write data
o_pipe_enable  out  1  pipeline advances this cycle
o_pipe_reset  out  1  pipeline/PC held in reset
o_state  out  3  current state encoding
o_cycle_count  out  NB_CYCLE  enabled cycles since run start
o_done  out  1  program halted; high in DONE
o_load_err  out  1  program overflowed memory without halt word

Behaviour:
- Clock and reset: i_clock, with i_reset synchronous and active-high. i_reset dominates everything.
- Reset values: state IDLE, o_pipe_reset=1, o_pipe_enable=0, o_mem_wr_en=0, address=0, assembly buffer=0, byte index=0, o_cycle_count=0, o_done=0, o_load_err=0.
- State encodings: IDLE=0, LOAD=1, RUN=2, STEP_WAIT=3, STEP_PULSE=4, DONE=5.
- Byte transfer: a byte is consumed only in a cycle with i_rx_valid&o_rx_ready.
  - o_rx_ready=1 in IDLE, LOAD, STEP_WAIT and DONE.
  - o_rx_ready=0 in RUN and STEP_PULSE.
- IDLE (commands consumed):
  - 0x4C 'L': clear address, byte index and o_load_err, then go to LOAD.
  - 0x43 'C': clear the counter, then go to RUN.
  - 0x53 'S': clear the counter, then go to STEP_WAIT.
  - Any other byte is consumed and ignored.
- LOAD:
  - Bytes are shifted in MSB-first.
  - On the 4th byte, assert o_mem_wr_en for exactly 1 cycle (the cycle after the accept), carrying the assembled word and the current address. The address increments after the write.
  - If the written word is 0 (halt), return to IDLE after the write.
  - If a non-zero word is written to address 2**NB_ADDR-1: set o_load_err, return to IDLE, and do not wrap the address.
- RUN:
  - o_pipe_enable=1 and the counter increments every cycle.
  - When i_halt=1 is sampled, go to DONE. o_pipe_enable is 0 from the next cycle, and that cycle is still counted.
- STEP_WAIT:
  - 0x4E 'N': go to STEP_PULSE.
  - 0x43 'C': go to RUN.
  - 0x53 'S' is ignored.
  - Any other byte returns to IDLE.
- STEP_PULSE:
  - o_pipe_enable=1 for exactly 1 cycle and the counter increments.
  - If i_halt=1, go to DONE; otherwise go to STEP_WAIT.
- DONE:
  - o_done=1; o_cycle_count is held.
  - Any byte is consumed and returns to IDLE.
- o_pipe_reset=1 in IDLE and LOAD, 0 in all other states, so the PC restarts at 0 on every run.
- Counter: saturates at all-ones; no wrap.
- Simultaneous events:
  - Halt in the same cycle as an incoming byte in RUN: the byte is not accepted (ready is low).
  - i_halt is ignored outside RUN and STEP_PULSE.
- Reset mid-LOAD discards the partial word; no write is issued.

Optional Feature:
CYCLE_LIMIT_EN
- Defined: in RUN, when o_cycle_count reaches MAX_CYCLES-1 and i_halt=0, go to DONE and set an added output o_timeout=1.
  - o_timeout clears on the next 'C' or 'S' command and on reset.
  - STEP mode is unaffected.
- Undefined: no watchdog, no o_timeout port; RUN lasts until i_halt.

Test Plan:
- Load path: reset, then 'L',0x20,0x01,0x00,0x05,0x00,0x00,0x00,0x00 -> writes 0x20010005 at addr 0 and 0x00000000 at addr 1, each with a 1-cycle o_mem_wr_en; state returns to IDLE; o_pipe_reset=1 throughout.
- Continuous run: 'C', with i_halt driven high after 7 enabled cycles -> o_pipe_enable high for exactly 8 cycles, o_done=1, o_cycle_count=8, o_rx_ready low during RUN.
- Stepping: 'S','N','N','N' -> exactly three 1-cycle o_pipe_enable pulses, o_cycle_count=3, state STEP_WAIT; then 'C' enters RUN.
- Load overflow with NB_ADDR=2: 'L' followed by 4 non-zero words -> 4 writes at addr 0..3, o_load_err=1, state IDLE, no 5th write.
- Resets and odd bytes:
  - i_reset after 2 bytes in LOAD -> no write, all outputs at reset values.
  - Byte 0x99 in IDLE -> ignored, state stays IDLE.
- CYCLE_LIMIT_EN with MAX_CYCLES=16 and i_halt held 0: 'C' -> DONE after 16 enabled cycles, o_timeout=1, o_cycle_count=16.
